// File: rtl/buf_pkg.sv
// Shared encodings for the merge pipeline: arbitration mode and source identifiers.
package buf_pkg;

  typedef enum logic {
    RR    = 1'b0,
    FIXED = 1'b1
  } prio_e;

  typedef enum logic {
    SRC1 = 1'b0,
    SRC2 = 1'b1
  } src_e;

  // Reset value of the last-grant record, so that the first contention goes to source 1.
  localparam src_e GRANT_RST = SRC2;

endpackage

// File: rtl/buf_stage.sv
// One elastic register stage: a valid bit with async reset, plus a data register
// that is written only when a real beat is loaded.
module buf_stage
  import buf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic             r_vld;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_vld <= i_vld;
    end
  end

  // Payload is don't-care while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_load && i_vld) begin
      r_data <= i_data;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/buf_merge_pipe.sv
// Two-source merge into a DEPTH-stage elastic pipeline, with round-robin or
// fixed-priority arbitration at the merge point and an occupancy counter.
module buf_merge_pipe
  import buf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in1_data,
  input  logic                       in1_valid,
  output logic                       in1_ready,
  input  logic [WIDTH-1:0]           in2_data,
  input  logic                       in2_valid,
  output logic                       in2_ready,
  input  logic                       prio_mode,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       grant_last
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] w_stg_vld;
  logic [DEPTH-1:0] w_load;
  logic [WIDTH-1:0] w_stg_data [DEPTH];
  logic             w_sel2;
  logic             w_acc1;
  logic             w_acc2;
  logic             w_in_vld;
  logic [WIDTH-1:0] w_in_data;
  logic             w_out_acc;
  src_e             r_grant_last;
  logic [OCC_W-1:0] r_occ;

  // Ready ripples from the sink back to stage 0: a stage loads if it is empty
  // or the stage after it loads this cycle.
  always_comb begin : ready_chain
    logic v_rdy;
    v_rdy = out_ready;
    for (int k = DEPTH-1; k >= 0; k--) begin
      w_load[k] = !w_stg_vld[k] || v_rdy;
      v_rdy     = w_load[k];
    end
  end

  always_comb begin
    w_sel2 = 1'b0;
    if (prio_e'(prio_mode) == FIXED) begin
      w_sel2 = !in1_valid;
    end else begin
      w_sel2 = in2_valid && (!in1_valid || (r_grant_last == SRC1));
    end
  end

  assign in1_ready = w_load[0] && !w_sel2;
  assign in2_ready = w_load[0] &&  w_sel2;
  assign w_acc1    = in1_valid && in1_ready;
  assign w_acc2    = in2_valid && in2_ready;
  assign w_in_vld  = w_acc1 || w_acc2;
  assign w_in_data = w_acc2 ? in2_data : in1_data;
  assign w_out_acc = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_last <= GRANT_RST;
    end else if (w_acc1) begin
      r_grant_last <= SRC1;
    end else if (w_acc2) begin
      r_grant_last <= SRC2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      case ({w_in_vld, w_out_acc})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             w_vi;
    logic [WIDTH-1:0] w_di;
    if (k == 0) begin : g_head
      assign w_vi = w_in_vld;
      assign w_di = w_in_data;
    end else begin : g_body
      assign w_vi = w_stg_vld[k-1];
      assign w_di = w_stg_data[k-1];
    end
    buf_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load[k]),
      .i_vld  (w_vi),
      .i_data (w_di),
      .o_vld  (w_stg_vld[k]),
      .o_data (w_stg_data[k])
    );
  end

  assign out_valid  = w_stg_vld[DEPTH-1];
  assign out_data   = w_stg_data[DEPTH-1];
  assign occupancy  = r_occ;
  assign grant_last = r_grant_last;

endmodule

// File: doc/buf_merge_pipe.md
BUF_MERGE_PIPE -- requirements
Module: buf_merge_pipe

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits (WIDTH >= 1).
REQ-002 Parameter DEPTH, default 4, number of register stages after the merge point (1..16).
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in1_data  input  WIDTH  payload, source 1.
REQ-006 Port in1_valid / in1_ready  input / output  1 each  source-1 handshake.
REQ-007 Port in2_data  input  WIDTH  payload, source 2.
REQ-008 Port in2_valid / in2_ready  input / output  1 each  source-2 handshake.
REQ-009 Port prio_mode  input  1  0 = round-robin, 1 = fixed priority to source 1.
REQ-010 Port out_data  output  WIDTH  payload from last stage.
REQ-011 Port out_valid / out_ready  output / input  1 each  sink handshake.
REQ-012 Port occupancy  output  $clog2(DEPTH+1)  count of valid stages.
REQ-013 Port grant_last  output  1  source of most recent accepted beat (0 = in1, 1 = in2).

Function
REQ-014 Transfer on any port occurs only when valid and ready are both high in the same cycle.
REQ-015 Stage k (k = 0 merge stage, DEPTH-1 output stage) holds a data register and a valid bit.
REQ-016 Stage k loads when empty or when stage k+1 (the sink for the last stage) takes its beat in the same cycle; ready propagates combinationally, so a full chain streams one beat per cycle.
REQ-017 Latency: a beat accepted at cycle t appears on out_data/out_valid at cycle t+DEPTH when no back-pressure occurs.
REQ-018 Arbiter: stage-0 ready offered to at most one source per cycle; in1_ready and in2_ready are never both high.
REQ-019 prio_mode=1: in1 wins whenever in1_valid; in2 gets ready only when in1_valid low.
REQ-020 prio_mode=0: on contention, grant goes to the source not equal to grant_last; a single requester always wins.
REQ-021 grant_last updates only on an accepted input beat; prio_mode changes take effect the next cycle, with no beat lost or duplicated.
REQ-022 in*_ready low for both sources when stage 0 cannot load, regardless of valid.
REQ-023 Beats leave in acceptance order; data never altered, dropped or duplicated.
REQ-024 occupancy increments on input-accept-only, decrements on output-accept-only, holds on both or neither; never exceeds DEPTH, never underflows.
REQ-025 out_data holds stable while out_valid high and out_ready low.

Reset
REQ-026 rst_n low clears all stage valid bits, occupancy=0, grant_last=1 (first round-robin contention grants in1); out_valid=0 asynchronously.
REQ-027 Data registers need not be reset; out_data is don't-care while out_valid=0.
REQ-028 Reset mid-stream discards all in-flight beats; first accept allowed in the first cycle after rst_n deasserts.

Structure
REQ-029 Shared package buf_pkg holds the prio-mode encodings (RR=0, FIXED=1) and the source-id encodings (SRC1=0, SRC2=1).
REQ-030 A single sub-module buf_stage (one elastic register stage, WIDTH-parametrised) is instantiated DEPTH times; arbiter and occupancy logic stay in the top.

Verification
REQ-031 DEPTH=4, out_ready=1, in1 sends 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 at cycles t+4..t+6, occupancy peaks at 3.
REQ-032 prio_mode=0, both valid for 6 cycles (in1 0xA0.., in2 0xB0..) -> output alternates A0,B0,A1,B1,A2,B2.
REQ-033 prio_mode=1, both valid -> only in1 beats accepted; in2_ready stays 0 until in1_valid drops.
REQ-034 out_ready=0 for 10 cycles with in1 streaming -> occupancy saturates at 4, in1_ready=0, out_data frozen; release -> 4 beats drain in order with no loss.
REQ-035 rst_n asserted with occupancy=3 -> out_valid=0 immediately, occupancy=0; post-reset beat 0x5A emerges 4 cycles after acceptance.
REQ-036 Random valid/ready on all ports for 10k cycles with scoreboard -> zero mismatches, in1_ready&in2_ready never both 1.
